sorted_insert: RTL and testbench

Writer-side companion to the lab 4 binary-search block. It inserts one 8-bit value per request into a 32x8 RAM and keeps the contents in ascending order, by shifting larger entries up one slot. The searcher then reads the same array through a separate read port. The block also tracks how many entries are valid and reports where each value landed.

---
 rtl/sorted_insert_pkg.sv | 15 +
 rtl/sorted_insert_if.sv | 19 +
 rtl/sorted_insert_ram32x8.sv | 21 ++
 rtl/sorted_insert.sv | 127 ++++++++++++
 tb/tb_sorted_insert.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/sorted_insert_pkg.sv
// Shared constants and FSM state type for the sorted-insert writer
// and its dual-port RAM.
package sorted_pkg;
  localparam int DEPTH  = 32;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CMP  = 3'd2,
    INS  = 3'd3,
    DONE = 3'd4
  } state_e;
endpackage

// File: rtl/sorted_insert_if.sv
// Request/response and searcher read-port bundle for sorted_insert.
interface sorted_insert_if;
  import sorted_pkg::*;
  logic              Start;
  logic [DATA_W-1:0] A;
  logic              Done;
  logic              Inserted;
  logic [ADDR_W-1:0] Loc;
  logic [ADDR_W:0]   Count;
  logic              Full;
  logic              Busy;
  logic [ADDR_W-1:0] RdAddr;
  logic [DATA_W-1:0] RdData;

  modport master (output Start, A, RdAddr,
                  input  Done, Inserted, Loc, Count, Full, Busy, RdData);
  modport slave  (input  Start, A, RdAddr,
                  output Done, Inserted, Loc, Count, Full, Busy, RdData);
endinterface

// File: rtl/sorted_insert_ram32x8.sv
// Dual-port RAM: port A read/write for the inserter, port B read-only
// for the searcher; both outputs registered.
module sorted_ram32x8
  import sorted_pkg::*;
(
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] data_a,
  input  logic              wren_a,
  output logic [DATA_W-1:0] q_a,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] q_b
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wren_a) mem[addr_a] <= data_a;
    q_a <= mem[addr_a];
    q_b <= mem[addr_b];
  end
endmodule

// File: rtl/sorted_insert.sv
// Keeps a 32-entry RAM in ascending order by shifting larger entries up
// one slot per compare, then writing the new value into the gap.
module sorted_insert
  import sorted_pkg::*;
(
  input  logic            clk,
  input  logic            Reset,
  sorted_insert_if.slave  bus
);
  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [ADDR_W-1:0] pos_q, pos_d;
  logic [ADDR_W-1:0] loc_q, loc_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ins_q, ins_d;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic [DATA_W-1:0] ram_q;
  logic              full;

  assign full = (count_q == DEPTH[ADDR_W:0]);

  sorted_ram32x8 u_ram (
    .clk    (clk),
    .addr_a (ram_addr),
    .data_a (ram_wdata),
    .wren_a (ram_we),
    .q_a    (ram_q),
    .addr_b (bus.RdAddr),
    .q_b    (bus.RdData)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    i_d       = i_q;
    pos_d     = pos_q;
    loc_d     = loc_q;
    count_d   = count_q;
    ins_d     = ins_q;
    ram_addr  = i_q;
    ram_wdata = a_q;
    ram_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          a_d   = bus.A;
          ins_d = 1'b0;
          if (full) begin
            state_d = DONE;
          end else if (count_q == '0) begin
            pos_d   = '0;
            state_d = INS;
          end else begin
            i_d     = count_q[ADDR_W-1:0] - 1'b1;
            state_d = RD;
          end
        end
      end
      RD: begin
        ram_addr = i_q;
        state_d  = CMP;
      end
      CMP: begin
        // Strictly-greater test keeps equal values ahead of the new one.
        if (ram_q > a_q) begin
          ram_addr  = i_q + 1'b1;
          ram_wdata = ram_q;
          ram_we    = 1'b1;
          if (i_q == '0) begin
            pos_d   = '0;
            state_d = INS;
          end else begin
            i_d     = i_q - 1'b1;
            state_d = RD;
          end
        end else begin
          pos_d   = i_q + 1'b1;
          state_d = INS;
        end
      end
      INS: begin
        ram_addr  = pos_q;
        ram_wdata = a_q;
        ram_we    = 1'b1;
        loc_d     = pos_q;
        count_d   = count_q + 1'b1;
        ins_d     = 1'b1;
        state_d   = DONE;
      end
      DONE: begin
        if (!bus.Start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      i_q     <= '0;
      pos_q   <= '0;
      loc_q   <= '0;
      count_q <= '0;
      ins_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      i_q     <= i_d;
      pos_q   <= pos_d;
      loc_q   <= loc_d;
      count_q <= count_d;
      ins_q   <= ins_d;
    end
  end

  assign bus.Done     = (state_q == DONE);
  assign bus.Inserted = ins_q;
  assign bus.Loc      = loc_q;
  assign bus.Count    = count_q;
  assign bus.Full     = full;
  assign bus.Busy     = (state_q == RD) || (state_q == CMP) || (state_q == INS);
endmodule

// File: tb/tb_sorted_insert.sv
// Scoreboard bench: driver pushes model-predicted results, monitor pops
// and compares on each rising Done.
module tb_sorted_insert;
  import sorted_pkg::*;

  logic clk = 1'b0;
  logic Reset = 1'b1;
  always #5 clk = ~clk;

  sorted_insert_if bif ();

  sorted_insert dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bif)
  );

  typedef struct {
    int a;
    bit ins;
    int loc;
    int cnt;
    int lat;
    int e0;
  } exp_t;

  exp_t sb_q[$];
  int   model_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: compares each completed operation against the scoreboard.
  initial begin
    bit   done_prev;
    exp_t e;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bif.Done && !done_prev) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          $display("txn a=%0d ins=%0d loc=%0d count=%0d lat=%0d", e.a,
                   bif.Inserted, bif.Loc, bif.Count, cyc - e.e0 + 1);
          chk("inserted", int'(bif.Inserted), int'(e.ins));
          if (e.ins) chk("loc", int'(bif.Loc), e.loc);
          chk("count", int'(bif.Count), e.cnt);
          chk("full", int'(bif.Full), int'(e.cnt == DEPTH));
          chk("latency", cyc - e.e0 + 1, e.lat);
          chk("busy_in_done", int'(bif.Busy), 0);
        end
      end
      done_prev = bif.Done;
    end
  end

  // Reference: new value goes after every entry <= it; each larger entry
  // costs one read+compare pair of cycles.
  function automatic exp_t predict(input int a);
    exp_t e;
    int   n, pos, k;
    n     = model_q.size();
    e.a   = a;
    e.e0  = 0;
    if (n == DEPTH) begin
      e.ins = 1'b0; e.loc = 0; e.cnt = n; e.lat = 1;
    end else begin
      pos = 0;
      foreach (model_q[j]) if (model_q[j] <= a) pos = j + 1;
      k = n - pos;
      e.ins = 1'b1; e.loc = pos; e.cnt = n + 1;
      e.lat = (k == n) ? 2 * k + 2 : 2 * k + 4;
      model_q.insert(pos, a);
    end
    return e;
  endfunction

  task automatic do_insert(input int a);
    exp_t e;
    int   waited;
    @(negedge clk);
    e = predict(a);
    e.e0 = cyc + 1;
    sb_q.push_back(e);
    bif.A     = a[DATA_W-1:0];
    bif.Start = 1'b1;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!bif.Done && waited < 200);
    if (!bif.Done) begin
      chk("done_timeout", 0, 1);
      void'(sb_q.pop_back());
    end
    @(negedge clk);
    chk("done_held", int'(bif.Done), 1);
    bif.Start = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_ram();
    for (int j = 0; j < model_q.size(); j++) begin
      bif.RdAddr = j[ADDR_W-1:0];
      @(negedge clk);
      @(negedge clk);
      chk($sformatf("ram[%0d]", j), int'(bif.RdData), model_q[j]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    Reset = 1'b1;
    bif.Start = 1'b0;
    @(negedge clk);
    Reset = 1'b0;
    model_q.delete();
    sb_q.delete();
  endtask

  initial begin
    bif.Start  = 1'b0;
    bif.A      = '0;
    bif.RdAddr = '0;
    repeat (2) @(negedge clk);
    Reset = 1'b0;
    @(negedge clk);
    chk("rst_done", int'(bif.Done), 0);
    chk("rst_inserted", int'(bif.Inserted), 0);
    chk("rst_loc", int'(bif.Loc), 0);
    chk("rst_count", int'(bif.Count), 0);
    chk("rst_full", int'(bif.Full), 0);
    chk("rst_busy", int'(bif.Busy), 0);

    do_insert(100);
    check_ram();
    do_insert(50);
    do_insert(200);
    do_insert(150);
    check_ram();
    do_insert(100);
    check_ram();

    do_reset();
    for (int v = 10; v <= 40; v++) do_insert(v);
    do_insert(0);
    check_ram();
    do_insert(77);
    check_ram();

    // Abort a shifting insert while it sits in CMP (cycle 2).
    do_reset();
    for (int j = 0; j < 5; j++) do_insert($urandom_range(10, 255));
    @(negedge clk);
    bif.A     = 8'd1;
    bif.Start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", int'(bif.Busy), 0);
    chk("abort_done", int'(bif.Done), 0);
    chk("abort_count", int'(bif.Count), 0);
    Reset = 1'b0;
    bif.Start = 1'b0;
    model_q.delete();
    sb_q.delete();
    @(negedge clk);
    do_insert(9);
    check_ram();

    do_reset();
    for (int j = 0; j < 36; j++) do_insert($urandom_range(0, 31));
    check_ram();

    repeat (4) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
